lane_scheduler: RTL

Frame-rate controller that decides when and where gameplay sprites (coins) are spawned across the three road lanes. It also tracks each in-flight sprite until it reaches the player row, and scores a collection when the player occupies that lane. It sits between the random generator and the per-lane spawn engines / sprite layer. It runs on the system clock, advanced by a one-cycle per-frame tick derived from vertical sync.

---
 rtl/lane_scheduler.sv | 132 +++++++++++++
 1 files changed

// File: rtl/lane_scheduler.sv
// Frame-rate sprite scheduler. It grants coin spawns to road lanes round-robin
// and tracks each sprite's travel time. A collection is scored when a sprite expires in the player's lane.
module lane_scheduler #(
    parameter int unsigned LANES         = 3,
    parameter int unsigned TRAVEL_FRAMES = 12,
    parameter int unsigned MIN_GAP       = 4,
    parameter int unsigned SCORE_W       = 16
) (
    input  logic               CLK100MHZ,
    input  logic               CPU_RESETN,
    input  logic               frame_tick,
    input  logic               enable,
    input  logic               clear,
    input  logic [19:0]        random,
    input  logic [1:0]         player_lane,
    output logic [LANES-1:0]   spawn,
    output logic [LANES-1:0]   busy,
    output logic               collect,
    output logic [SCORE_W-1:0] score
);

    localparam int unsigned LIFE_W = 8;
    localparam int unsigned GAP_W  = 8;
    localparam int unsigned RR_W   = 2;
    localparam int unsigned RAND_W = 20;

    logic [LIFE_W-1:0]  life_q [LANES];
    logic [LIFE_W-1:0]  life_d [LANES];
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [RR_W-1:0]    rr_q, rr_d;
    logic [SCORE_W-1:0] score_d;
    logic [LANES-1:0]   spawn_d;
    logic               collect_d;
    logic [LANES-1:0]   req_c;
    logic               found_c;
    logic [RR_W-1:0]    gidx_c;
    logic [RR_W-1:0]    cand_c;
    logic               unused_rand_c;

    // Request bits above the last lane's triple carry no meaning here.
    assign unused_rand_c = ^random[RAND_W-1:3*LANES];

    // Lane requests and round-robin pick starting at rr
    always_comb begin
        req_c   = '0;
        found_c = 1'b0;
        gidx_c  = '0;
        cand_c  = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            req_c[i] = (&random[3*i +: 3]) && (life_q[i] == '0);
        end
        for (int k = 0; k < int'(LANES); k++) begin
            cand_c = RR_W'((int'(rr_q) + k) % int'(LANES));
            if (!found_c && req_c[cand_c]) begin
                found_c = 1'b1;
                gidx_c  = cand_c;
            end
        end
    end

    // Next-state: lives, expiry/score, gap and grant, all from pre-tick values
    always_comb begin
        for (int i = 0; i < int'(LANES); i++) begin
            life_d[i] = life_q[i];
        end
        gap_d     = gap_q;
        rr_d      = rr_q;
        score_d   = score;
        spawn_d   = '0;
        collect_d = 1'b0;

        if (clear) begin
            for (int i = 0; i < int'(LANES); i++) begin
                life_d[i] = '0;
            end
            gap_d   = '0;
            rr_d    = '0;
            score_d = '0;
        end else if (frame_tick) begin
            for (int i = 0; i < int'(LANES); i++) begin
                if (life_q[i] != '0) begin
                    life_d[i] = life_q[i] - LIFE_W'(1);
                end
                if ((life_q[i] == LIFE_W'(1)) && (player_lane == RR_W'(i))) begin
                    collect_d = 1'b1;
                end
            end
            if (collect_d && (score != '1)) begin
                score_d = score + SCORE_W'(1);
            end
            if (gap_q != '0) begin
                gap_d = gap_q - GAP_W'(1);
            end else if (enable && found_c) begin
                spawn_d[gidx_c] = 1'b1;
                life_d[gidx_c]  = LIFE_W'(TRAVEL_FRAMES);
                gap_d           = GAP_W'(MIN_GAP);
                rr_d            = RR_W'((int'(gidx_c) + 1) % int'(LANES));
            end
        end
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            for (int i = 0; i < int'(LANES); i++) begin
                life_q[i] <= '0;
            end
            gap_q   <= '0;
            rr_q    <= '0;
            score   <= '0;
            spawn   <= '0;
            collect <= 1'b0;
        end else begin
            for (int i = 0; i < int'(LANES); i++) begin
                life_q[i] <= life_d[i];
            end
            gap_q   <= gap_d;
            rr_q    <= rr_d;
            score   <= score_d;
            spawn   <= spawn_d;
            collect <= collect_d;
        end
    end

    // Occupancy decoded straight from the registered lives
    always_comb begin
        busy = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            busy[i] = (life_q[i] != '0);
        end
    end

endmodule
